// File: rtl/mem_stage_pkg.sv
// Shared definitions for the mips32 MEM stage: FSM encodings, timeout default, alignment helper.
package mem_stage_pkg;

    typedef enum logic {
        MemSt_Idle = 1'b0,
        MemSt_Wait = 1'b1
    } mem_state_e;

    localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;
    localparam logic [1:0]  MEM_ALIGN_MASK      = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return (lsb & MEM_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with load, bubble-insert (priority) and synchronous active-low reset.
module mem_wb_reg #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_bubble,
    input  logic              i_valid,
    input  logic              i_reg_write,
    input  logic              i_mem_to_reg,
    input  logic [4:0]        i_reg_rd,
    input  logic [DATA_W-1:0] i_alu_out,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic              o_valid,
    output logic              o_reg_write,
    output logic              o_mem_to_reg,
    output logic [4:0]        o_reg_rd,
    output logic [DATA_W-1:0] o_alu_out,
    output logic [DATA_W-1:0] o_mem_data
);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_bubble) begin
            o_valid      <= 1'b0;
            o_reg_write  <= 1'b0;
            o_mem_to_reg <= 1'b0;
            o_reg_rd     <= '0;
            o_alu_out    <= '0;
            o_mem_data   <= '0;
        end else if (i_load) begin
            o_valid      <= i_valid;
            o_reg_write  <= i_reg_write;
            o_mem_to_reg <= i_mem_to_reg;
            o_reg_rd     <= i_reg_rd;
            o_alu_out    <= i_alu_out;
            o_mem_data   <= i_mem_data;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mips32 MEM stage: data-memory req/ack FSM, pipeline stall and MEM/WB register.
// Optional bus-timeout abort enabled by defining MEM_TIMEOUT_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              EXMEM_Valid,
    input  logic [DATA_W-1:0] EXMEM_ALUOut,
    input  logic [DATA_W-1:0] EXMEM_WriteData,
    input  logic [4:0]        EXMEM_RegRd,
    input  logic              EXMEM_RegWrite,
    input  logic              EXMEM_MemRead,
    input  logic              EXMEM_MemWrite,
    input  logic              EXMEM_MemToReg,
    output logic              DMem_Req,
    output logic              DMem_We,
    output logic [DATA_W-1:0] DMem_Addr,
    output logic [DATA_W-1:0] DMem_WData,
    input  logic              DMem_Ack,
    input  logic [DATA_W-1:0] DMem_RData,
    output logic              MemStall,
    output logic              MEMWB_Valid,
    output logic              MEMWB_RegWrite,
    output logic              MEMWB_MemToReg,
    output logic [4:0]        MEMWB_RegRd,
    output logic [DATA_W-1:0] MEMWB_ALUOut,
    output logic [DATA_W-1:0] MEMWB_MemData,
    output logic              AddrErr,
    output logic              BusErr
);

    mem_state_e        r_state;
    mem_state_e        w_state_nxt;
    logic              r_req, r_we, r_addr_err, r_bus_err;
    logic [DATA_W-1:0] r_addr, r_wdata;
    logic              w_memop, w_misal, w_timeout;
    logic              w_issue, w_done, w_stall, w_load, w_bubble;
    logic              w_wb_reg_write, w_addr_err_nxt, w_bus_err_nxt;
    logic [DATA_W-1:0] w_wb_mem_data;

    assign w_memop = EXMEM_Valid & (EXMEM_MemRead | EXMEM_MemWrite);
    assign w_misal = is_misaligned(EXMEM_ALUOut[1:0]);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    // Counts WAIT cycles since issue; abort fires when it reaches the limit.
    always_ff @(posedge Clock) begin
        if (!Reset || w_issue) begin
            r_cnt <= '0;
        end else if (r_state == MemSt_Wait) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == MemSt_Wait) && (r_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state <= MemSt_Idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ack takes priority over timeout so a late-but-valid completion is never lost.
    always_comb begin
        w_state_nxt    = r_state;
        w_issue        = 1'b0;
        w_done         = 1'b0;
        w_stall        = 1'b0;
        w_load         = 1'b0;
        w_bubble       = 1'b0;
        w_wb_reg_write = EXMEM_RegWrite;
        w_wb_mem_data  = '0;
        w_addr_err_nxt = 1'b0;
        w_bus_err_nxt  = 1'b0;
        case (r_state)
            MemSt_Idle: begin
                if (w_memop && w_misal) begin
                    w_load         = 1'b1;
                    w_wb_reg_write = 1'b0;
                    w_addr_err_nxt = 1'b1;
                end else if (w_memop) begin
                    w_stall     = 1'b1;
                    w_issue     = 1'b1;
                    w_bubble    = 1'b1;
                    w_state_nxt = MemSt_Wait;
                end else begin
                    w_load = 1'b1;
                end
            end
            MemSt_Wait: begin
                if (DMem_Ack) begin
                    w_load        = 1'b1;
                    w_done        = 1'b1;
                    w_wb_mem_data = EXMEM_MemRead ? DMem_RData : '0;
                    w_state_nxt   = MemSt_Idle;
                end else if (w_timeout) begin
                    w_load         = 1'b1;
                    w_done         = 1'b1;
                    w_wb_reg_write = 1'b0;
                    w_bus_err_nxt  = 1'b1;
                    w_state_nxt    = MemSt_Idle;
                end else begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end
            end
            default: w_state_nxt = MemSt_Idle;
        endcase
    end

    // Request latch: captured at issue, held through WAIT, request dropped on completion.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_addr_err <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_addr_err <= w_addr_err_nxt;
            r_bus_err  <= w_bus_err_nxt;
            if (w_issue) begin
                r_req   <= 1'b1;
                r_we    <= EXMEM_MemWrite;
                r_addr  <= EXMEM_ALUOut;
                r_wdata <= EXMEM_WriteData;
            end else if (w_done) begin
                r_req <= 1'b0;
            end
        end
    end

    assign DMem_Req   = r_req;
    assign DMem_We    = r_we;
    assign DMem_Addr  = r_addr;
    assign DMem_WData = r_wdata;
    assign AddrErr    = r_addr_err;
    assign BusErr     = r_bus_err;
    assign MemStall   = w_stall & Reset;

    mem_wb_reg #(
        .DATA_W(DATA_W)
    ) u_mem_wb_reg (
        .i_clk        (Clock),
        .i_rst_n      (Reset),
        .i_load       (w_load),
        .i_bubble     (w_bubble),
        .i_valid      (EXMEM_Valid),
        .i_reg_write  (w_wb_reg_write),
        .i_mem_to_reg (EXMEM_MemToReg),
        .i_reg_rd     (EXMEM_RegRd),
        .i_alu_out    (EXMEM_ALUOut),
        .i_mem_data   (w_wb_mem_data),
        .o_valid      (MEMWB_Valid),
        .o_reg_write  (MEMWB_RegWrite),
        .o_mem_to_reg (MEMWB_MemToReg),
        .o_reg_rd     (MEMWB_RegRd),
        .o_alu_out    (MEMWB_ALUOut),
        .o_mem_data   (MEMWB_MemData)
    );

endmodule
